seq_pattern_gen: RTL and testbench
==================================

// Module: seq_pattern_gen
// PURPOSE
//  Serial pattern transmitter: the sending end of the serial sequence-detect link.
//  On start, latches a PAT_W-bit pattern and a repeat count.
//  Shifts the pattern out MSB-first on seqout, one bit per clk.
//  Optional idle gap between repetitions; done pulse on completion.
//  Feeds serial detector FSMs; bench stimulus source for them.
// PARAMETERS
//  PAT_W  3  pattern width in bits (>=2); default pattern use is 3'b110
//  CNT_W  4  repeat-count width; up to 2**CNT_W-1 repetitions
//  GAP    1  idle cycles between repetitions (0 = back-to-back)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request; sampled only in IDLE
//  abort      in   1      synchronous cancel; any state -> IDLE
//  pattern    in   PAT_W  pattern to send, latched on accepted start
//  reps       in   CNT_W  repetition count, latched on accepted start; 0 treated as 1
//  seqout     out  1      serial data, MSB of pattern first
//  seq_valid  out  1      high while seqout carries a pattern bit
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle pulse after the final bit
// BEHAVIOUR
//  Moore FSM, one-hot: IDLE, SHIFT, GAP, DONE.
//  All outputs decode from registered state/datapath only; no input->output comb path.
//  Reset (rst=1 at an edge, priority over all else):
//   - state=IDLE; seqout=0, seq_valid=0, busy=0, done=0
//   - pat_reg, bit_idx, rep_cnt, gap_cnt = 0
//  IDLE, start=1 (accepted start):
//   - pat_reg<=pattern; rep_cnt<=(reps==0)?1:reps; bit_idx<=PAT_W-1; -> SHIFT
//   - Latency: start high at edge N -> seqout=pattern[PAT_W-1], seq_valid=1 after N.
//  SHIFT:
//   - seqout=pat_reg[bit_idx], seq_valid=1; bit_idx decrements each edge.
//   - At bit_idx==0: rep_cnt-=1.
//     - Old rep_cnt==1 -> DONE.
//     - Else GAP>0 -> GAP (gap_cnt<=GAP-1).
//     - Else stay in SHIFT, bit_idx<=PAT_W-1.
//  GAP:
//   - seqout=0, seq_valid=0, busy=1.
//   - gap_cnt==0 -> SHIFT, bit_idx<=PAT_W-1; else decrement.
//  DONE:
//   - done=1, busy=1, seqout=0, seq_valid=0 for exactly one cycle; -> IDLE.
//  Ignored inputs:
//   - start in SHIFT/GAP/DONE: no effect.
//   - pattern/reps changes after acceptance: no effect.
//  abort=1 at any edge with rst=0, state!=IDLE:
//   - -> IDLE next cycle; seq_valid drops immediately after that edge; no done pulse.
//  abort and start together in IDLE: abort wins; start not accepted.
//  Reset mid-transfer: same as reset; partial pattern discarded, no done.
//  Timing: one burst occupies reps*PAT_W + (reps-1)*GAP + 1 busy cycles.
//  Cadence: start may be re-accepted the cycle after DONE (IDLE).
// TESTING
//  1) pattern=110, reps=1, start 1 cyc
//     -> seqout 1,1,0 with seq_valid=1 for 3 cyc; done=1 on 4th cyc; busy 4 cyc.
//  2) pattern=110, reps=2, GAP=1
//     -> 1,1,0, one gap cycle (valid=0, seqout=0), 1,1,0, done; busy=8 cyc.
//  3) reps=0 -> identical to reps=1; pattern change after start -> output unchanged.
//  4) start held high through whole burst -> single burst; new burst begins 1 cyc after done.
//  5) abort during 2nd bit -> seq_valid=0, busy=0 next cycle; done never asserted.
//  6) rst asserted during GAP -> all outputs 0 next cycle.
//     Then start with pattern=101 -> clean 1,0,1 burst.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: latches a pattern and repeat count on start and
// shifts it out MSB-first, with an optional idle gap between repetitions.
module seq_pattern_gen #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    output logic             seqout,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(PAT_W);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_SHIFT = 4'b0010;
    localparam logic [3:0] S_GAP   = 4'b0100;
    localparam logic [3:0] S_DONE  = 4'b1000;

    logic [3:0]       state;
    logic [PAT_W-1:0] pat_reg;
    logic [IDX_W-1:0] bit_idx;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pat_reg <= '0;
            bit_idx <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
        end else if (abort) begin
            // Cancel wins over everything, including a start seen in IDLE.
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pat_reg <= pattern;
                        rep_cnt <= (reps == '0) ? CNT_W'(1) : reps;
                        bit_idx <= IDX_TOP;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_idx == '0) begin
                        rep_cnt <= rep_cnt - 1'b1;
                        if (rep_cnt == CNT_W'(1)) begin
                            state <= S_DONE;
                        end else if (GAP > 0) begin
                            gap_cnt <= GAP_TOP;
                            state   <= S_GAP;
                        end else begin
                            bit_idx <= IDX_TOP;
                        end
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        bit_idx <= IDX_TOP;
                        state   <= S_SHIFT;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs: decoded from registered state and datapath only.
    assign seqout    = (state == S_SHIFT) & pat_reg[bit_idx];
    assign seq_valid = (state == S_SHIFT);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen; outputs are checked each cycle as the
// packed code {seqout, seq_valid, busy, done}.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [2:0] pattern;
    logic [3:0] reps;
    logic       seqout;
    logic       seq_valid;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    seq_pattern_gen #(.PAT_W(3), .CNT_W(4), .GAP(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .pattern  (pattern),
        .reps     (reps),
        .seqout   (seqout),
        .seq_valid(seq_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Output codes {seqout, seq_valid, busy, done}
    localparam logic [3:0] O_IDLE = 4'b0000;
    localparam logic [3:0] O_B1   = 4'b1110;
    localparam logic [3:0] O_B0   = 4'b0110;
    localparam logic [3:0] O_GAP  = 4'b0010;
    localparam logic [3:0] O_DONE = 4'b0011;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [3:0] exp);
        check(tag, {seqout, seq_valid, busy, done}, exp);
        tick();
    endtask

    task automatic send(input logic [2:0] pat, input logic [3:0] r);
        pattern = pat;
        reps    = r;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; reps = '0;
        tick();
        tick();
        rst = 1'b0;
        cyc("reset0", O_IDLE);
        cyc("reset1", O_IDLE);

        // 1) single repetition of 110
        send(3'b110, 4'd1);
        cyc("t1_b2", O_B1);
        cyc("t1_b1", O_B1);
        cyc("t1_b0", O_B0);
        cyc("t1_done", O_DONE);
        cyc("t1_idle", O_IDLE);

        // 2) two repetitions with one gap cycle
        send(3'b110, 4'd2);
        cyc("t2_r0b2", O_B1);
        cyc("t2_r0b1", O_B1);
        cyc("t2_r0b0", O_B0);
        cyc("t2_gap", O_GAP);
        cyc("t2_r1b2", O_B1);
        cyc("t2_r1b1", O_B1);
        cyc("t2_r1b0", O_B0);
        cyc("t2_done", O_DONE);
        cyc("t2_idle", O_IDLE);

        // 3) reps=0 behaves as 1; inputs changed after acceptance are ignored
        send(3'b110, 4'd0);
        pattern = 3'b001;
        reps    = 4'd5;
        cyc("t3_b2", O_B1);
        cyc("t3_b1", O_B1);
        cyc("t3_b0", O_B0);
        cyc("t3_done", O_DONE);
        cyc("t3_idle", O_IDLE);

        // 4) start held high: one burst, next begins one cycle after done
        pattern = 3'b110;
        reps    = 4'd1;
        start   = 1'b1;
        tick();
        cyc("t4_b2", O_B1);
        cyc("t4_b1", O_B1);
        cyc("t4_b0", O_B0);
        cyc("t4_done", O_DONE);
        cyc("t4_idle", O_IDLE);
        start = 1'b0;
        cyc("t4_n_b2", O_B1);
        cyc("t4_n_b1", O_B1);
        cyc("t4_n_b0", O_B0);
        cyc("t4_n_done", O_DONE);
        cyc("t4_n_idle", O_IDLE);

        // 5) abort during the second bit; no done afterwards
        send(3'b110, 4'd2);
        cyc("t5_b2", O_B1);
        check("t5_b1", {seqout, seq_valid, busy, done}, O_B1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cyc("t5_ab0", O_IDLE);
        cyc("t5_ab1", O_IDLE);
        cyc("t5_ab2", O_IDLE);
        cyc("t5_ab3", O_IDLE);

        // abort together with start in IDLE: start not accepted
        pattern = 3'b110;
        reps    = 4'd1;
        start   = 1'b1;
        abort   = 1'b1;
        tick();
        start   = 1'b0;
        abort   = 1'b0;
        cyc("t5_as0", O_IDLE);
        cyc("t5_as1", O_IDLE);

        // 6) reset during GAP, then a clean 101 burst
        send(3'b110, 4'd2);
        cyc("t6_b2", O_B1);
        cyc("t6_b1", O_B1);
        cyc("t6_b0", O_B0);
        check("t6_gap", {seqout, seq_valid, busy, done}, O_GAP);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc("t6_rst", O_IDLE);
        send(3'b101, 4'd1);
        cyc("t6_p2", O_B1);
        cyc("t6_p1", O_B0);
        cyc("t6_p0", O_B1);
        cyc("t6_done", O_DONE);
        cyc("t6_idle", O_IDLE);

        // 7) leading zero bit still carries seq_valid
        send(3'b011, 4'd1);
        cyc("t7_p2", O_B0);
        cyc("t7_p1", O_B1);
        cyc("t7_p0", O_B1);
        cyc("t7_done", O_DONE);
        cyc("t7_idle", O_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
